// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4-to-1 mux; grants are registered and held.
// Define HOLD_TIMEOUT_EN to compile in the forced release after MAX_HOLD cycles.
module mux_select_arbiter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] selector_bits,
   output logic [3:0] grant,
   output logic       grant_valid,
   output logic       timeout_pulse
);

   typedef enum logic {StIdle, StGranted} state_e;

   state_e     state;
   logic [1:0] ptr;
   logic [1:0] arb_ptr;
   logic [1:0] win;
   logic       have_win;
   logic       timeout_hit;
   logic       release_now;
   logic       forced;

   if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : gen_bad_params
      $error("mux_select_arbiter: illegal MAX_HOLD/CNT_W combination");
   end

`ifdef HOLD_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] hold_cnt;

   assign timeout_hit = (hold_cnt == HoldLast);
`else
   assign timeout_hit = 1'b0;
`endif

   assign release_now = (state == StGranted) &&
                        (done || !req[selector_bits] || timeout_hit);
   // A timeout coinciding with done or a dropped request is an ordinary release.
   assign forced      = timeout_hit && !done && req[selector_bits];

   // On release the just-served channel moves to lowest priority.
   always_comb begin
      arb_ptr  = (state == StGranted) ? selector_bits + 2'd1 : ptr;
      have_win = 1'b0;
      win      = arb_ptr;
      for (int i = 3; i >= 0; i--) begin
         if (req[arb_ptr + 2'(i)]) begin
            have_win = 1'b1;
            win      = arb_ptr + 2'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= StIdle;
         ptr           <= 2'd0;
         selector_bits <= 2'd0;
         grant         <= 4'd0;
         grant_valid   <= 1'b0;
         timeout_pulse <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
         hold_cnt      <= '0;
`endif
      end else begin
         timeout_pulse <= 1'b0;
         unique case (state)
            StIdle: begin
               if (have_win) begin
                  state         <= StGranted;
                  selector_bits <= win;
                  grant         <= 4'b0001 << win;
                  grant_valid   <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
                  hold_cnt      <= '0;
`endif
               end
            end
            StGranted: begin
               if (release_now) begin
                  ptr           <= selector_bits + 2'd1;
                  timeout_pulse <= forced;
                  if (have_win) begin
                     selector_bits <= win;
                     grant         <= 4'b0001 << win;
`ifdef HOLD_TIMEOUT_EN
                     hold_cnt      <= '0;
`endif
                  end else begin
                     state       <= StIdle;
                     grant       <= 4'd0;
                     grant_valid <= 1'b0;
                  end
               end
`ifdef HOLD_TIMEOUT_EN
               else if (hold_cnt != HoldMax) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
`endif
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
